// File: rtl/cov_accum_if.sv
// Stream bundle for cov_accum: 512-bit product input beats in, one 32-bit
// covariance lane per beat out with valid/ready/last.
interface cov_accum_if #(
    parameter int unsigned LANES = 16
);
    logic [32*LANES-1:0] axis_di0;
    logic                axis_vi0;
    logic [31:0]         axis_do;
    logic                axis_vo;
    logic                axis_ro;
    logic                axis_lo;

    modport master (
        output axis_di0, axis_vi0, axis_ro,
        input  axis_do, axis_vo, axis_lo
    );

    modport slave (
        input  axis_di0, axis_vi0, axis_ro,
        output axis_do, axis_vo, axis_lo
    );
endinterface

// File: rtl/cov_accum.sv
// Covariance frame accumulator: sums N = 2^LOG2_N product vectors per lane,
// averages by arithmetic shift and streams the 16 results out lane by lane.
module cov_accum #(
    parameter int unsigned LOG2_N = 10,
    parameter int unsigned LANES  = 16
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        en,
    cov_accum_if.slave  axis,
    output logic        ovf,
    output logic [15:0] frame_cnt
);
    localparam int unsigned AW = 32 + LOG2_N;
    localparam int unsigned IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    typedef enum logic {EMPTY, SEND} state_e;

    logic signed [AW-1:0] acc_q [LANES];
    logic signed [AW-1:0] acc_d [LANES];
    logic signed [AW-1:0] sum   [LANES];
    logic        [31:0]   lane  [LANES];
    logic        [31:0]   buf_q [LANES];
    logic        [31:0]   buf_d [LANES];
    logic [LOG2_N-1:0]    cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 accept, frame_done, last_xfer, load;

    // Accumulator datapath; the Nth beat's sum bypasses the register so the
    // buffer load and the accumulator clear happen on the same edge.
    always_comb begin
        accept     = en & axis.axis_vi0;
        frame_done = accept && (cnt_q == '1);
        for (int unsigned k = 0; k < LANES; k++) begin
            lane[k]  = axis.axis_di0[32*k +: 32];
            sum[k]   = acc_q[k] + $signed({{LOG2_N{lane[k][31]}}, lane[k]});
            acc_d[k] = acc_q[k];
            if (!en || frame_done) begin
                acc_d[k] = '0;
            end else if (accept) begin
                acc_d[k] = sum[k];
            end
        end
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;
        last_xfer   = (state_q == SEND) && axis.axis_ro && (idx_q == LAST_IDX);
        load        = frame_done && ((state_q == EMPTY) || last_xfer);

        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (axis.axis_ro) begin
                    if (last_xfer) begin
                        state_d = load ? SEND : EMPTY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                idx_d   = '0;
            end
        endcase

        if (load) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                buf_d[k] = sum[k][AW-1:LOG2_N];
            end
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (frame_done && !load) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            acc_q       <= '{default: '0};
            buf_q       <= '{default: '0};
            cnt_q       <= '0;
            state_q     <= EMPTY;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        axis.axis_vo = (state_q == SEND);
        axis.axis_lo = (state_q == SEND) && (idx_q == LAST_IDX);
        axis.axis_do = (state_q == SEND) ? buf_q[idx_q] : '0;
        ovf          = ovf_q;
        frame_cnt    = frame_cnt_q;
    end
endmodule

// File: tb/tb_cov_accum.sv
// Directed bench for cov_accum: an N=4 instance for the main scenarios and an
// N=16 instance for back-to-back frames whose load meets the last transfer.
module tb_cov_accum;
    logic        aclk;
    logic        reset;
    logic        en_a, en_b;
    logic        ovf_a, ovf_b;
    logic [15:0] fc_a, fc_b;
    logic [31:0] lv [16];
    int          pass_cnt;
    int          fail_cnt;
    int          total_cnt;

    cov_accum_if #(.LANES(16)) ifa ();
    cov_accum_if #(.LANES(16)) ifb ();

    cov_accum #(.LOG2_N(2), .LANES(16)) dut_a (
        .aclk      (aclk),
        .reset     (reset),
        .en        (en_a),
        .axis      (ifa.slave),
        .ovf       (ovf_a),
        .frame_cnt (fc_a)
    );

    cov_accum #(.LOG2_N(4), .LANES(16)) dut_b (
        .aclk      (aclk),
        .reset     (reset),
        .en        (en_b),
        .axis      (ifb.slave),
        .ovf       (ovf_b),
        .frame_cnt (fc_b)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack();
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = lv[k];
        return v;
    endfunction

    task automatic set_all(input logic [31:0] val);
        for (int k = 0; k < 16; k++) lv[k] = val;
        ifa.axis_di0 = pack();
    endtask

    // Drain 16 beats from DUT A with ready high, expecting every lane = val.
    task automatic drain_const_a(input string tag, input logic [31:0] val);
        for (int j = 0; j < 16; j++) begin
            chk({tag, "_do"}, ifa.axis_do, val);
            chk({tag, "_lo"}, {31'd0, ifa.axis_lo}, {31'd0, j == 15});
            tick();
        end
        chk({tag, "_vo_end"}, {31'd0, ifa.axis_vo}, 32'd0);
    endtask

    initial begin
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        reset = 1'b1; en_a = 1'b1; en_b = 1'b1;
        ifa.axis_di0 = '0; ifa.axis_vi0 = 1'b0; ifa.axis_ro = 1'b1;
        ifb.axis_di0 = '0; ifb.axis_vi0 = 1'b0; ifb.axis_ro = 1'b1;
        set_all(32'd0);
        tick();
        tick();
        reset = 1'b0;

        chk("rst_vo", {31'd0, ifa.axis_vo}, 32'd0);
        chk("rst_lo", {31'd0, ifa.axis_lo}, 32'd0);
        chk("rst_do", ifa.axis_do, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("rst_fc", {16'd0, fc_a}, 32'd0);

        // Lane k = k+1 for four beats: averages 1..16 in lane order.
        for (int k = 0; k < 16; k++) lv[k] = 32'(k + 1);
        ifa.axis_di0 = pack();
        ifa.axis_vi0 = 1'b1;
        tick(); tick(); tick();
        chk("lat_vo_before", {31'd0, ifa.axis_vo}, 32'd0);
        tick();
        ifa.axis_vi0 = 1'b0;
        chk("lat_vo_after", {31'd0, ifa.axis_vo}, 32'd1);
        chk("lat_fc", {16'd0, fc_a}, 32'd1);
        for (int j = 0; j < 16; j++) begin
            chk("seq_do", ifa.axis_do, 32'(j + 1));
            chk("seq_lo", {31'd0, ifa.axis_lo}, {31'd0, j == 15});
            tick();
        end
        chk("seq_vo_end", {31'd0, ifa.axis_vo}, 32'd0);

        // Extreme values must survive the widened sum without wrapping.
        set_all(32'd0);
        lv[0] = 32'hFFFF_FFF8; lv[1] = 32'h7FFF_FFFF; lv[2] = 32'h8000_0000;
        ifa.axis_di0 = pack();
        ifa.axis_vi0 = 1'b1;
        tick(); tick(); tick(); tick();
        ifa.axis_vi0 = 1'b0;
        chk("ext_l0", ifa.axis_do, 32'hFFFF_FFF8);
        tick();
        chk("ext_l1", ifa.axis_do, 32'h7FFF_FFFF);
        tick();
        chk("ext_l2", ifa.axis_do, 32'h8000_0000);
        for (int j = 0; j < 14; j++) tick();
        chk("ext_vo_end", {31'd0, ifa.axis_vo}, 32'd0);
        chk("ext_fc", {16'd0, fc_a}, 32'd2);

        // Floor rounding: lane0 1,2,3,5 -> 2; lane1 -1,-1,-1,-2 -> -2.
        set_all(32'd0);
        ifa.axis_vi0 = 1'b1;
        lv[0] = 32'd1; lv[1] = 32'hFFFF_FFFF; ifa.axis_di0 = pack(); tick();
        lv[0] = 32'd2; ifa.axis_di0 = pack(); tick();
        lv[0] = 32'd3; ifa.axis_di0 = pack(); tick();
        lv[0] = 32'd5; lv[1] = 32'hFFFF_FFFE; ifa.axis_di0 = pack(); tick();
        ifa.axis_vi0 = 1'b0;
        chk("flr_l0", ifa.axis_do, 32'd2);
        tick();
        chk("flr_l1", ifa.axis_do, 32'hFFFF_FFFE);
        for (int j = 0; j < 15; j++) tick();
        chk("flr_vo_end", {31'd0, ifa.axis_vo}, 32'd0);

        // Backpressure: second frame arrives while the first is held -> dropped.
        ifa.axis_ro = 1'b0;
        for (int k = 0; k < 16; k++) lv[k] = 32'(100 + k);
        ifa.axis_di0 = pack();
        ifa.axis_vi0 = 1'b1;
        tick(); tick(); tick(); tick();
        chk("bp_vo", {31'd0, ifa.axis_vo}, 32'd1);
        chk("bp_fc1", {16'd0, fc_a}, 32'd4);
        for (int k = 0; k < 16; k++) lv[k] = 32'(200 + k);
        ifa.axis_di0 = pack();
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("bp_hold_do", ifa.axis_do, 32'd100);
            chk("bp_hold_lo", {31'd0, ifa.axis_lo}, 32'd0);
        end
        ifa.axis_vi0 = 1'b0;
        chk("bp_ovf", {31'd0, ovf_a}, 32'd1);
        chk("bp_fc2", {16'd0, fc_a}, 32'd4);
        ifa.axis_ro = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("bp_do", ifa.axis_do, 32'(100 + j));
            tick();
        end
        chk("bp_vo_end", {31'd0, ifa.axis_vo}, 32'd0);
        chk("bp_ovf_sticky", {31'd0, ovf_a}, 32'd1);

        // Reset clears sticky state; a reset mid-frame discards partial sums.
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_ovf", {31'd0, ovf_a}, 32'd0);
        chk("rst2_fc", {16'd0, fc_a}, 32'd0);
        set_all(32'd99);
        ifa.axis_vi0 = 1'b1;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        set_all(32'd4);
        tick(); tick(); tick();
        chk("mid_rst_vo_before", {31'd0, ifa.axis_vo}, 32'd0);
        tick();
        ifa.axis_vi0 = 1'b0;
        chk("mid_rst_vo", {31'd0, ifa.axis_vo}, 32'd1);
        chk("mid_rst_fc", {16'd0, fc_a}, 32'd1);
        drain_const_a("mid_rst", 32'd4);

        // en low for one beat restarts the frame.
        set_all(32'd50);
        ifa.axis_vi0 = 1'b1;
        tick(); tick();
        en_a = 1'b0; tick(); en_a = 1'b1;
        set_all(32'd8);
        tick(); tick(); tick();
        chk("en_vo_before", {31'd0, ifa.axis_vo}, 32'd0);
        tick();
        ifa.axis_vi0 = 1'b0;
        chk("en_vo", {31'd0, ifa.axis_vo}, 32'd1);
        chk("en_fc", {16'd0, fc_a}, 32'd2);
        drain_const_a("en", 32'd8);

        // N=16: two back-to-back frames, second load meets last transfer.
        for (int k = 0; k < 16; k++) ifb.axis_di0[32*k +: 32] = 32'(k + 1);
        ifb.axis_vi0 = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("b2b_vo", {31'd0, ifb.axis_vo}, 32'd1);
        for (int k = 0; k < 16; k++) ifb.axis_di0[32*k +: 32] = 32'(2 * (k + 1));
        for (int j = 0; j < 16; j++) begin
            chk("b2b_f1_do", ifb.axis_do, 32'(j + 1));
            chk("b2b_f1_lo", {31'd0, ifb.axis_lo}, {31'd0, j == 15});
            tick();
        end
        ifb.axis_vi0 = 1'b0;
        chk("b2b_vo_kept", {31'd0, ifb.axis_vo}, 32'd1);
        chk("b2b_ovf", {31'd0, ovf_b}, 32'd0);
        chk("b2b_fc", {16'd0, fc_b}, 32'd2);
        for (int j = 0; j < 16; j++) begin
            chk("b2b_f2_do", ifb.axis_do, 32'(2 * (j + 1)));
            tick();
        end
        chk("b2b_vo_end", {31'd0, ifb.axis_vo}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
